// File: rtl/bcd_seg_scan_if.sv
// Bus between a display controller and the bcd_seg_scan digit scanner.
// The master side supplies the BCD value, load strobe and display options;
// the slave side (the scanner) returns the segment, decimal-point, anode and
// frame signals.
interface bcd_seg_scan_if;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame;

  modport master (
    output load, bcd_in, dp_in, lz_en,
    input  seg, dp_n, an, frame
  );

  modport slave (
    input  load, bcd_in, dp_in, lz_en,
    output seg, dp_n, an, frame
  );
endinterface

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A value captured on load is held pending and only becomes the displayed
// value at the end of a full scan, so one scan never mixes old and new
// digits. Each digit slot opens with a short all-off guard to stop ghosting
// between anodes. Outputs are registered and lag the scan state by one clock.
module bcd_seg_scan #(
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  bcd_seg_scan_if.slave bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  // Active-low gfedcba pattern for one BCD nibble; non-decimal codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = 7'h3F;
    endcase
    return pat;
  endfunction

  logic [CNT_W-1:0] div_cnt_r;
  logic [1:0]       idx_r;
  logic [19:0]      pend_r;
  logic             pend_v_r;
  logic [19:0]      act_r;
  logic [6:0]       seg_r;
  logic             dp_n_r;
  logic [3:0]       an_r;
  logic             frame_r;

  logic             slot_end_s;
  logic             frame_edge_s;
  logic             blank_phase_s;
  logic [3:0]       zero_s;
  logic [3:0]       nib_s;
  logic             dp_s;
  logic [3:0]       an_drive_s;
  logic             lz_blank_s;
  logic [6:0]       seg_s;

  assign slot_end_s    = (div_cnt_r == DIV_LAST);
  assign frame_edge_s  = slot_end_s && (idx_r == 2'd3);
  assign blank_phase_s = (div_cnt_r < BLANK_END);

  assign zero_s[0] = (act_r[3:0]   == 4'h0);
  assign zero_s[1] = (act_r[7:4]   == 4'h0);
  assign zero_s[2] = (act_r[11:8]  == 4'h0);
  assign zero_s[3] = (act_r[15:12] == 4'h0);

  // Select the current digit's nibble, dp bit, anode pattern and zero-blanking.
  always_comb begin
    nib_s      = 4'h0;
    dp_s       = 1'b0;
    an_drive_s = 4'hF;
    lz_blank_s = 1'b0;
    seg_s      = 7'h7F;
    case (idx_r)
      2'd0: begin
        nib_s      = act_r[3:0];
        dp_s       = act_r[16];
        an_drive_s = 4'b1110;
        lz_blank_s = 1'b0;
      end
      2'd1: begin
        nib_s      = act_r[7:4];
        dp_s       = act_r[17];
        an_drive_s = 4'b1101;
        lz_blank_s = bus.lz_en & zero_s[3] & zero_s[2] & zero_s[1];
      end
      2'd2: begin
        nib_s      = act_r[11:8];
        dp_s       = act_r[18];
        an_drive_s = 4'b1011;
        lz_blank_s = bus.lz_en & zero_s[3] & zero_s[2];
      end
      2'd3: begin
        nib_s      = act_r[15:12];
        dp_s       = act_r[19];
        an_drive_s = 4'b0111;
        lz_blank_s = bus.lz_en & zero_s[3];
      end
      default: begin
        nib_s      = 4'h0;
        dp_s       = 1'b0;
        an_drive_s = 4'hF;
        lz_blank_s = 1'b0;
      end
    endcase
    if (lz_blank_s) begin
      seg_s = 7'h7F;
    end else begin
      seg_s = seg_decode(nib_s);
    end
  end

  // Advance the dwell counter and step to the next digit at the end of each slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r <= {CNT_W{1'b0}};
      idx_r     <= 2'd0;
    end else if (slot_end_s) begin
      div_cnt_r <= {CNT_W{1'b0}};
      idx_r     <= idx_r + 2'd1;
    end else begin
      div_cnt_r <= div_cnt_r + CNT_W'(1);
    end
  end

  // Hold loads as pending and promote them to the displayed value only at a frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r   <= 20'h0_0000;
      pend_v_r <= 1'b0;
      act_r    <= 20'h0_0000;
    end else if (frame_edge_s) begin
      if (bus.load) begin
        act_r    <= {bus.dp_in, bus.bcd_in};
        pend_v_r <= 1'b0;
      end else if (pend_v_r) begin
        act_r    <= pend_r;
        pend_v_r <= 1'b0;
      end
    end else if (bus.load) begin
      pend_r   <= {bus.dp_in, bus.bcd_in};
      pend_v_r <= 1'b1;
    end
  end

  // Register the display outputs: all-off during the guard, else drive the current digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_r    <= 4'hF;
      seg_r   <= 7'h7F;
      dp_n_r  <= 1'b1;
      frame_r <= 1'b0;
    end else begin
      frame_r <= frame_edge_s;
      if (blank_phase_s) begin
        an_r   <= 4'hF;
        seg_r  <= 7'h7F;
        dp_n_r <= 1'b1;
      end else begin
        an_r   <= an_drive_s;
        seg_r  <= seg_s;
        dp_n_r <= ~dp_s;
      end
    end
  end

  assign bus.seg   = seg_r;
  assign bus.dp_n  = dp_n_r;
  assign bus.an    = an_r;
  assign bus.frame = frame_r;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan with a short dwell (8 clocks, 2 blank).
// Stimulus pushes the expected per-edge outputs into a queue tagged with the
// absolute edge number; a monitor on the falling edge pops and compares.
module tb_bcd_seg_scan;

  localparam int RD = 8;
  localparam int BC = 2;

  typedef struct {
    int         pe;
    int         scen;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       frame;
  } exp_t;

  logic clk;
  logic reset;
  bcd_seg_scan_if bus ();

  bcd_seg_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t sbq[$];
  int   pe = 0;
  int   base = 0;
  int   scen = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) pe <= pe + 1;

  // Monitor: compare every expectation due at this edge against the outputs.
  always @(negedge clk) begin : monitor
    exp_t x;
    while (sbq.size() > 0 && sbq[0].pe <= pe) begin
      x = sbq.pop_front();
      n_tests++;
      if (x.pe != pe || bus.an !== x.an || bus.seg !== x.seg ||
          bus.dp_n !== x.dp_n || bus.frame !== x.frame) begin
        n_fail++;
        $display("FAIL s%0d edge %0d: got an=%h seg=%h dp_n=%b frame=%b, want an=%h seg=%h dp_n=%b frame=%b (due edge %0d)",
                 x.scen, pe - base, bus.an, bus.seg, bus.dp_n, bus.frame,
                 x.an, x.seg, x.dp_n, x.frame, x.pe - base);
      end
    end
  end

  task automatic wait_edge(input int n);
    while (pe < base + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    base = pe;
  endtask

  // Expected outputs for edges e0..e1; segs packs {d3,d2,d1,d0}, dpn is {d3..d0}.
  task automatic push_range(input int e0, input int e1,
                            input logic [27:0] segs, input logic [3:0] dpn);
    for (int e = e0; e <= e1; e++) begin
      exp_t x;
      int t;
      int dv;
      int ix;
      t  = e - 1;
      dv = t % RD;
      ix = (t / RD) % 4;
      x.pe   = base + e;
      x.scen = scen;
      if (dv < BC) begin
        x.an   = 4'hF;
        x.seg  = 7'h7F;
        x.dp_n = 1'b1;
      end else begin
        x.an     = 4'hF;
        x.an[ix] = 1'b0;
        x.seg    = segs[ix*7 +: 7];
        x.dp_n   = dpn[ix];
      end
      x.frame = (dv == RD - 1) && (ix == 3);
      sbq.push_back(x);
    end
  endtask

  task automatic load_at(input int e, input logic [15:0] v, input logic [3:0] dp);
    wait_edge(e - 1);
    bus.load   = 1'b1;
    bus.bcd_in = v;
    bus.dp_in  = dp;
    wait_edge(e);
    bus.load   = 1'b0;
  endtask

  localparam logic [27:0] ALL0 = {7'h40, 7'h40, 7'h40, 7'h40};

  initial begin : stim
    exp_t r;
    reset      = 1'b1;
    bus.load   = 1'b0;
    bus.bcd_in = 16'h0000;
    bus.dp_in  = 4'h0;
    bus.lz_en  = 1'b0;

    // S1: idle scan after reset, blank/drive timing and frame pulse.
    scen = 1;
    do_reset();
    push_range(1, 40, ALL0, 4'b1111);
    wait_edge(40);

    // S2: load 0537 with dp on digit 2; visible only after the frame boundary.
    scen = 2;
    do_reset();
    push_range(1, 32, ALL0, 4'b1111);
    push_range(33, 64, {7'h40, 7'h12, 7'h30, 7'h78}, 4'b1011);
    load_at(5, 16'h0537, 4'b0100);
    bus.bcd_in = 16'hFFFF;
    bus.dp_in  = 4'hF;
    wait_edge(64);

    // S3: leading-zero suppression on the same value, then an all-zero value.
    scen = 3;
    bus.lz_en = 1'b1;
    push_range(65, 96, {7'h7F, 7'h12, 7'h30, 7'h78}, 4'b1011);
    push_range(97, 128, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
    load_at(70, 16'h0000, 4'b0000);
    wait_edge(128);
    bus.lz_en = 1'b0;

    // S4: two loads in one frame, last one wins.
    scen = 4;
    do_reset();
    push_range(1, 32, ALL0, 4'b1111);
    push_range(33, 64, {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);
    load_at(10, 16'h1111, 4'b0000);
    load_at(20, 16'h2222, 4'b0000);
    wait_edge(64);

    // S5: load coincident with the boundary overrides and clears a pending load.
    scen = 5;
    do_reset();
    push_range(1, 32, ALL0, 4'b1111);
    push_range(33, 96, {7'h12, 7'h10, 7'h12, 7'h10}, 4'b1111);
    push_range(97, 128, {7'h40, 7'h40, 7'h3F, 7'h40}, 4'b1111);
    load_at(20, 16'h1234, 4'b0000);
    load_at(32, 16'h5959, 4'b0000);
    load_at(70, 16'h00A0, 4'b0000);
    wait_edge(128);

    // S6: asynchronous reset mid-drive of digit 2 drops the pending load.
    scen = 6;
    do_reset();
    push_range(1, 20, ALL0, 4'b1111);
    r.pe    = base + 21;
    r.scen  = scen;
    r.an    = 4'hF;
    r.seg   = 7'h7F;
    r.dp_n  = 1'b1;
    r.frame = 1'b0;
    sbq.push_back(r);
    load_at(10, 16'h1111, 4'b0000);
    wait_edge(21);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    base = pe;
    push_range(1, 64, ALL0, 4'b1111);
    wait_edge(64);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && sbq.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
